// File: rtl/piso_bit_serializer.sv
// piso_bit_serializer
//   Parallel-in/serial-out stage feeding the "11" Mealy sequence detector.
//   Words are accepted over a valid/ready handshake and shifted out one bit
//   per clock. Back-to-back words stream with no idle gap.
//
//   Optional feature macro: SER_PARITY_EN
//     When defined, each frame is followed by one even-parity bit (XOR of
//     the data bits), making frames WIDTH+1 cycles long.
//
// Parameters
//   WIDTH      word width (2..32)
//   MSB_FIRST  1: din[WIDTH-1] first, 0: din[0] first
//   IDLE_LEVEL level on ser_out whenever ser_valid=0
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   din        parallel word
//   din_valid  source presents a word
//   din_ready  word can be accepted this cycle (combinational)
//   ser_out    serial bit to the detector's in
//   ser_valid  ser_out carries payload
//   busy       frame in progress
//   done       pulse on the last payload cycle of a frame
module piso_bit_serializer #(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef SER_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] sh, sh_n;
  logic             ser_out_n, ser_valid_n, done_n, busy_n;
  logic             accept;
`ifdef SER_PARITY_EN
  logic             par, par_n;
`endif

  // Bit that leaves first from a word, given the configured bit order.
  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  // Drop the bit just sent so the next one sits at the head position.
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  // Ready depends only on state/counter (and rst), never on din_valid.
  always_comb begin
    din_ready = 1'b0;
    if (!rst) begin
      unique case (state)
        IDLE:   din_ready = 1'b1;
`ifdef SER_PARITY_EN
        SHIFT:  din_ready = 1'b0;
        PARITY: din_ready = 1'b1;
`else
        SHIFT:  din_ready = (cnt == LAST);
`endif
        default: din_ready = 1'b0;
      endcase
    end
  end

  assign accept = din_valid & din_ready;

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    sh_n        = sh;
    ser_out_n   = IDLE_LEVEL;
    ser_valid_n = 1'b0;
    done_n      = 1'b0;
`ifdef SER_PARITY_EN
    par_n       = par;
`endif

    unique case (state)
      IDLE: ;
      SHIFT: begin
        if (cnt != LAST) begin
          ser_out_n   = head_bit(sh);
          sh_n        = advance(sh);
          cnt_n       = cnt + CW'(1);
          ser_valid_n = 1'b1;
`ifndef SER_PARITY_EN
          done_n      = (cnt_n == LAST);
`endif
        end else begin
`ifdef SER_PARITY_EN
          state_n     = PARITY;
          ser_out_n   = par;
          ser_valid_n = 1'b1;
          done_n      = 1'b1;
`else
          state_n     = IDLE;
          cnt_n       = '0;
`endif
        end
      end
`ifdef SER_PARITY_EN
      PARITY: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
`endif
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase

    // A load overrides the frame-end decision, giving zero-gap streaming.
    if (accept) begin
      state_n     = SHIFT;
      cnt_n       = '0;
      ser_out_n   = head_bit(din);
      sh_n        = advance(din);
      ser_valid_n = 1'b1;
      done_n      = 1'b0;
`ifdef SER_PARITY_EN
      par_n       = ^din;
`endif
    end

    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      sh        <= '0;
      ser_out   <= IDLE_LEVEL;
      ser_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef SER_PARITY_EN
      par       <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      sh        <= sh_n;
      ser_out   <= ser_out_n;
      ser_valid <= ser_valid_n;
      busy      <= busy_n;
      done      <= done_n;
`ifdef SER_PARITY_EN
      par       <= par_n;
`endif
    end
  end

endmodule

// File: doc/piso_bit_serializer.md
Name: piso_bit_serializer

Overview:
- Parallel-in/serial-out stage directly upstream of the "11" Mealy sequence detector.
- Accepts WIDTH-bit words through a valid/ready handshake and shifts them out one bit per clock.
- ser_out drives the detector's `in` port; ser_valid tells downstream logic which cycles carry payload.
- Back-to-back words stream with no idle gap.

Parameters:
- WIDTH, 8: word width in bits; legal range 2..32.
- MSB_FIRST, 1: 1 = bit WIDTH-1 goes out first; 0 = bit 0 goes out first.
- IDLE_LEVEL, 0: value driven on ser_out whenever ser_valid=0.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- din  input  WIDTH  parallel word to serialize.
- din_valid  input  1  source has a word on din.
- din_ready  output  1  block can accept a word this cycle.
- ser_out  output  1  serial bit; connects to the detector's in.
- ser_valid  output  1  ser_out carries a payload bit this cycle.
- busy  output  1  frame in progress (state != IDLE).
- done  output  1  one-cycle pulse on the cycle the final bit of a frame is on ser_out.

Behaviour:
- Reset and registers:
  - Single clock domain. Reset is synchronous and active-high, sampled on the rising edge of clk.
  - Reset values: ser_out=IDLE_LEVEL, ser_valid=0, busy=0, done=0, FSM=IDLE, bit counter=0, shift register=0.
  - din_ready is forced 0 while rst=1.
  - All outputs except din_ready are registered. din_ready is combinational from state and counter only, never from din_valid.
- Accept rule: a word is taken at any rising edge where din_valid=1 and din_ready=1. The source must hold din stable until then.
- Latency: the first bit appears on ser_out in the cycle immediately after the accept edge. Bits then occupy WIDTH consecutive cycles, with ser_valid=1 on each.
- Bit order: MSB_FIRST=1 sends din[WIDTH-1] down to din[0]; MSB_FIRST=0 sends din[0] up to din[WIDTH-1].
- FSM states:
  - IDLE: din_ready=1. On accept, load the shift register, set counter=0, go to SHIFT. Otherwise ser_out=IDLE_LEVEL and ser_valid=0.
  - SHIFT: present the current bit and increment the counter each cycle. din_ready=1 only on the last-bit cycle (counter=WIDTH-1).
    - If a word is accepted on that last-bit cycle, reload and stay in SHIFT. The next frame's first bit follows with zero gap.
    - If no word is accepted, return to IDLE.
  - PARITY: exists only under the optional feature (see below).
- done is 1 on the final payload cycle of each frame (the parity cycle when that feature is compiled in) and 0 otherwise.
- busy=1 in SHIFT and PARITY.
- Boundary conditions:
  - din_valid while din_ready=0: ignored, no state change, no word lost.
  - rst asserted mid-frame: the frame is aborted at that edge. Outputs go to reset values the next cycle, and the remaining bits are discarded.
  - rst and din_valid high in the same cycle: rst wins, the word is not accepted.
  - Counter width is $clog2(WIDTH+1). The counter never wraps past WIDTH-1 in SHIFT.

Optional Feature:
- Macro: SER_PARITY_EN.
- When defined:
  - After the WIDTH data bits, FSM enters PARITY for one cycle.
  - ser_out = even-parity bit (XOR of all WIDTH data bits), with ser_valid=1 and done=1 on that cycle.
  - Frame length is WIDTH+1 cycles.
  - din_ready is 1 in the PARITY cycle, not on the last data bit. Back-to-back accepts occur there.
- When not defined:
  - The PARITY state, parity logic and parity register are absent.
  - Frame length is WIDTH cycles.

Test Plan:
- Basic frame (WIDTH=8, MSB_FIRST=1): din=8'hB3 accepted at edge k -> ser_out over cycles k+1..k+8 is 1,0,1,1,0,0,1,1 with ser_valid=1 throughout; done=1 only at k+8. The attached detector gives z=1 at k+4 and k+8.
- Back-to-back: 8'hFF then 8'h00 with din_valid held -> 16 contiguous ser_valid cycles, ser_out eight 1s then eight 0s. din_ready=1 exactly at the 8th bit; done pulses twice.
- LSB-first (MSB_FIRST=0): din=8'h01 -> ser_out 1,0,0,0,0,0,0,0.
- Backpressure: din_valid=1 with 8'hAA while busy mid-frame -> no accept until the last-bit cycle. The word is then sent intact as 1,0,1,0,1,0,1,0.
- Reset mid-frame: rst=1 at bit 3 of 8'hB3 -> next cycle ser_valid=0, ser_out=IDLE_LEVEL, busy=0, done=0. A subsequent 8'h0F is serialized cleanly as 0,0,0,0,1,1,1,1.
- SER_PARITY_EN defined: din=8'hB3 (five 1s) -> 9 valid cycles ending in parity bit 1, with done on the 9th. din=8'h03 -> parity bit 0.
